// File: rtl/attn_phase_sequencer.sv
// Scheduler for the self-attention engine. It reads and checks the input and
// weight headers, then issues five matmul jobs on the shared datapath, one
// after another: Q, K, V, S = Q*K^T and Z = S*V.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a start request, outputs hold their last values
// S_HDR_WAIT  | header read in flight (one-cycle SRAM latency)
// S_HDR_CAP   | capture N, D, M and weight rows Dw
// S_CHECK     | validate the headers, load the phase-0 configuration
// S_ISSUE     | mm_start high for this single cycle
// S_WAIT_DONE | wait for mm_done of the current job
// S_DONE      | run finished (or aborted on a header error)
module attn_phase_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic [ADDR_W-1:0] sram_input_read_address,
    input  logic [DATA_W-1:0] sram_input_read_data,
    output logic [ADDR_W-1:0] sram_weight_read_address,
    input  logic [DATA_W-1:0] sram_weight_read_data,
    output logic              mm_start,
    input  logic              mm_done,
    output logic [1:0]        mm_a_src,
    output logic [1:0]        mm_b_src,
    output logic [ADDR_W-1:0] mm_a_base,
    output logic [ADDR_W-1:0] mm_b_base,
    output logic [ADDR_W-1:0] mm_dst_base,
    output logic              mm_b_transpose,
    output logic [DIM_W-1:0]  mm_rows,
    output logic [DIM_W-1:0]  mm_inner,
    output logic [DIM_W-1:0]  mm_cols,
    output logic [2:0]        phase,
    output logic              err,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_WAIT, S_HDR_CAP, S_CHECK, S_ISSUE, S_WAIT_DONE, S_DONE
    } state_t;

    localparam logic [1:0] SRC_IN  = 2'd0;
    localparam logic [1:0] SRC_WT  = 2'd1;
    localparam logic [1:0] SRC_RES = 2'd2;

    state_t             state_q, state_d;
    logic               ready_q, ready_d, start_q, start_d;
    logic [1:0]         a_src_q, a_src_d, b_src_q, b_src_d;
    logic [ADDR_W-1:0]  a_base_q, a_base_d, b_base_q, b_base_d, dst_q, dst_d;
    logic               trans_q, trans_d;
    logic [DIM_W-1:0]   rows_q, rows_d, inner_q, inner_d, cols_q, cols_d;
    logic [2:0]         phase_q, phase_d;
    logic               err_q, err_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [DIM_W-1:0]   n_q, n_d, d_q, d_d, m_q, m_d, dw_q, dw_d;
    logic               cfg_load;

    logic [2:0]         cfg_phase;
    logic [1:0]         cfg_a_src, cfg_b_src;
    logic [ADDR_W-1:0]  cfg_a_base, cfg_b_base, cfg_dst;
    logic               cfg_trans;
    logic [DIM_W-1:0]   cfg_rows, cfg_inner, cfg_cols;
    logic [ADDR_W-1:0]  n_a, d_a, m_a, p_sz, w_sz, p3, one_a;

    assign sram_input_read_address  = '0;
    assign sram_weight_read_address = '0;

    // Address arithmetic wraps at ADDR_W by construction.
    assign n_a   = ADDR_W'(n_q);
    assign d_a   = ADDR_W'(d_q);
    assign m_a   = ADDR_W'(m_q);
    assign one_a = ADDR_W'(1);
    assign p_sz  = n_a * m_a;
    assign w_sz  = d_a * m_a;
    assign p3    = p_sz + p_sz + p_sz;

    // Job configuration for the phase about to be loaded (0 from CHECK, else phase+1).
    always_comb begin
        cfg_phase  = (state_q == S_CHECK) ? 3'd0 : phase_q + 3'd1;
        cfg_a_src  = SRC_IN;
        cfg_b_src  = SRC_WT;
        cfg_a_base = one_a;
        cfg_b_base = one_a;
        cfg_dst    = '0;
        cfg_trans  = 1'b0;
        cfg_rows   = n_q;
        cfg_inner  = d_q;
        cfg_cols   = m_q;
        case (cfg_phase)
            3'd1: begin
                cfg_b_base = one_a + w_sz;
                cfg_dst    = p_sz;
            end
            3'd2: begin
                cfg_b_base = one_a + w_sz + w_sz;
                cfg_dst    = p_sz + p_sz;
            end
            3'd3: begin
                cfg_a_src  = SRC_RES;
                cfg_b_src  = SRC_RES;
                cfg_a_base = '0;
                cfg_b_base = p_sz;
                cfg_dst    = p3;
                cfg_trans  = 1'b1;
                cfg_inner  = m_q;
                cfg_cols   = n_q;
            end
            3'd4: begin
                cfg_a_src  = SRC_RES;
                cfg_b_src  = SRC_RES;
                cfg_a_base = p3;
                cfg_b_base = p_sz + p_sz;
                cfg_dst    = p3 + n_a * n_a;
                cfg_inner  = n_q;
            end
            default: ;
        endcase
    end

    // Sequencer next-state, header capture, status and configuration loading.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        d_d      = d_q;
        m_d      = m_q;
        dw_d     = dw_q;
        cfg_load = 1'b0;
        if (state_q != S_IDLE && cnt_q != 32'hFFFF_FFFF)
            cnt_d = cnt_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                if (dut_valid) begin
                    state_d = S_HDR_WAIT;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    phase_d = '0;
                end
            end
            S_HDR_WAIT: state_d = S_HDR_CAP;
            S_HDR_CAP: begin
                n_d     = DIM_W'(sram_input_read_data[31:16]);
                d_d     = DIM_W'(sram_input_read_data[15:0]);
                dw_d    = DIM_W'(sram_weight_read_data[31:16]);
                m_d     = DIM_W'(sram_weight_read_data[15:0]);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (n_q == '0 || d_q == '0 || m_q == '0 || dw_q != d_q) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cfg_load = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (mm_done) begin
                    if (phase_q == 3'd4) begin
                        state_d = S_DONE;
                    end else begin
                        phase_d  = phase_q + 3'd1;
                        cfg_load = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        a_src_d  = cfg_load ? cfg_a_src  : a_src_q;
        b_src_d  = cfg_load ? cfg_b_src  : b_src_q;
        a_base_d = cfg_load ? cfg_a_base : a_base_q;
        b_base_d = cfg_load ? cfg_b_base : b_base_q;
        dst_d    = cfg_load ? cfg_dst    : dst_q;
        trans_d  = cfg_load ? cfg_trans  : trans_q;
        rows_d   = cfg_load ? cfg_rows   : rows_q;
        inner_d  = cfg_load ? cfg_inner  : inner_q;
        cols_d   = cfg_load ? cfg_cols   : cols_q;
        ready_d  = (state_d == S_IDLE);
        start_d  = (state_d == S_ISSUE);
    end

    // State and output registers; reset abandons any in-flight job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
            a_src_q  <= '0;
            b_src_q  <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            dst_q    <= '0;
            trans_q  <= 1'b0;
            rows_q   <= '0;
            inner_q  <= '0;
            cols_q   <= '0;
            phase_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            n_q      <= '0;
            d_q      <= '0;
            m_q      <= '0;
            dw_q     <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            a_src_q  <= a_src_d;
            b_src_q  <= b_src_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            dst_q    <= dst_d;
            trans_q  <= trans_d;
            rows_q   <= rows_d;
            inner_q  <= inner_d;
            cols_q   <= cols_d;
            phase_q  <= phase_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            d_q      <= d_d;
            m_q      <= m_d;
            dw_q     <= dw_d;
        end
    end

    assign dut_ready      = ready_q;
    assign mm_start       = start_q;
    assign mm_a_src       = a_src_q;
    assign mm_b_src       = b_src_q;
    assign mm_a_base      = a_base_q;
    assign mm_b_base      = b_base_q;
    assign mm_dst_base    = dst_q;
    assign mm_b_transpose = trans_q;
    assign mm_rows        = rows_q;
    assign mm_inner       = inner_q;
    assign mm_cols        = cols_q;
    assign phase          = phase_q;
    assign err            = err_q;
    assign cycle_count    = cnt_q;

endmodule

// File: doc/attn_phase_sequencer.md
# attn_phase_sequencer

Top-level scheduler for the self-attention engine. It sits between the testbench handshake (`dut_valid`/`dut_ready`) and a single shared matrix-multiply datapath. It reads the input and weight SRAM headers, checks them, then issues five matmul jobs in order: Q=I·Wq, K=I·Wk, V=I·Wv, S=Q·Kᵀ, Z=S·V. For each job it drives the operand sources, base addresses, dimensions and transpose control, and waits for that job's completion before issuing the next.

## Interface
Parameters:
- `ADDR_W`, 16: SRAM address width.
- `DATA_W`, 32: SRAM data width.
- `DIM_W`, 16: matrix dimension field width.

Ports:
- `clk` in 1: clock. One clock domain only.
- `reset_n` in 1: reset, asynchronous and active-low.
- `dut_valid` in 1: start request from the testbench.
- `dut_ready` out 1: high only when the block is idle.
- `sram_input_read_address` out ADDR_W: header address. Held at 0.
- `sram_input_read_data` in DATA_W: input header. [31:16]=N rows, [15:0]=D cols.
- `sram_weight_read_address` out ADDR_W: header address. Held at 0.
- `sram_weight_read_data` in DATA_W: weight header. [31:16]=D rows, [15:0]=M cols.
- `mm_start` out 1: one-cycle job-start pulse.
- `mm_done` in 1: one-cycle job-complete pulse from the engine.
- `mm_a_src`, `mm_b_src` out 2 each: operand source. 0=input SRAM, 1=weight SRAM, 2=result SRAM.
- `mm_a_base`, `mm_b_base`, `mm_dst_base` out ADDR_W each: operand and destination base addresses. The destination is always the result SRAM.
- `mm_b_transpose` out 1: read B column-major.
- `mm_rows`, `mm_inner`, `mm_cols` out DIM_W each: job dimensions.
- `phase` out 3: current job, 0..4.
- `err` out 1: sticky header-error flag.
- `cycle_count` out 32: busy-cycle count of the last run.

## Operation
States: IDLE, HDR_WAIT, HDR_CAP, CHECK, ISSUE, WAIT_DONE, DONE.

Transitions:
- IDLE: moves to HDR_WAIT when `dut_valid`=1. On acceptance, clear `err`, `cycle_count` and `phase`.
- HDR_WAIT → HDR_CAP. This covers the one-cycle SRAM read latency.
- HDR_CAP: capture N, D, M and weight rows Dw into registers. Go to CHECK.
- CHECK: if N=0, D=0, M=0 or Dw≠D, set `err` and go to DONE with no `mm_start`. Otherwise load the phase-0 configuration and go to ISSUE.
- ISSUE: assert `mm_start` for this cycle only. Go to WAIT_DONE.
- WAIT_DONE: on `mm_done`:
  - if `phase`=4, go to DONE;
  - otherwise increment `phase`, load the new configuration, and go to ISSUE.
- DONE → IDLE.

Per-phase configuration. Let P=N·M and Wsz=D·M.
- Phase 0 (Q): A=input, base 1. B=weight, base 1. dst 0. Dimensions (N, D, M).
- Phase 1 (K): A=input, base 1. B=weight, base 1+Wsz. dst P. Dimensions (N, D, M).
- Phase 2 (V): A=input, base 1. B=weight, base 1+2·Wsz. dst 2P. Dimensions (N, D, M).
- Phase 3 (S): A=result, base 0. B=result, base P, transpose=1. dst 3P. Dimensions (N, M, N).
- Phase 4 (Z): A=result, base 3P. B=result, base 2P. dst 3P+N·N. Dimensions (N, N, M).
- `mm_b_transpose`=0 in every phase except phase 3.

Arithmetic: address products and sums are unsigned, truncated to ADDR_W, and wrap silently. There is no overflow detection.

Configuration outputs are registered. They stay stable from ISSUE until the next configuration load. They hold their last values in DONE and IDLE.

Ignored inputs:
- `dut_valid` outside IDLE.
- `mm_done` outside WAIT_DONE. This includes `mm_done` during the ISSUE cycle.

`cycle_count` increments on every non-IDLE cycle and saturates at 2³²−1. It holds its value in IDLE.

## Timing
- Reset values: `dut_ready`=1, `mm_start`=0, all configuration outputs 0, `phase`=0, `err`=0, `cycle_count`=0, addresses 0. State is IDLE.
- Reset asserted mid-operation takes effect immediately (asynchronous). The block returns to IDLE with the values above; the in-flight job is abandoned.
- `dut_ready` is a registered output, equal to (state==IDLE).
- Accept cycle T (IDLE with `dut_valid`=1): `dut_ready`=0 from T+1. HDR_WAIT at T+1, HDR_CAP at T+2, CHECK at T+3, first ISSUE at T+4.
- If the engine returns `mm_done` L≥1 cycles after `mm_start`, the next ISSUE comes L+1 cycles after the previous one.
- After the final `mm_done` at cycle X: DONE at X+1, `dut_ready`=1 at X+2.
- Error path: DONE at T+4, `dut_ready`=1 at T+5, `cycle_count`=4.

## Test plan
- Nominal run: N=4, D=8, M=8 (input header 0x00040008, weight header 0x00080008), engine L=5.
  - Exactly five `mm_start` pulses, at T+4, T+10, T+16, T+22, T+28.
  - Bases (a, b, dst): (1, 1, 0), (1, 65, 32), (1, 129, 64), (0, 32, 96) with transpose=1, (96, 64, 112).
  - S dimensions (4, 8, 4); Z dimensions (4, 4, 8).
  - `dut_ready` returns at T+35; `cycle_count`=34; `err`=0.
- Input header 0x00000008 (N=0) → `err`=1, no `mm_start`, `dut_ready` at T+5, `cycle_count`=4.
- Weight header 0x00060008 with D=8 (Dw mismatch) → `err`=1, no `mm_start`.
  - A following valid run clears `err` at acceptance.
- Stray `mm_done` in IDLE and during ISSUE, plus `dut_valid` held high through the whole run → no phase skip; exactly five jobs; one run only.
- Engine L=1 (`mm_done` the cycle after every `mm_start`) → starts at T+4, 6, 8, 10, 12; `dut_ready` at T+15.
- `reset_n` pulsed low during WAIT_DONE of phase 2 → outputs take reset values immediately with no clock edge needed. The next run then behaves exactly as the nominal run.
